fetch_stage: RTL and testbench

Fetch stage that sits directly downstream of pc_mux: owns the architectural PC register, drives pc_current/add_pc_out back to pc_mux, and consumes pc_mux's pc_next.
Issues instruction-memory requests over a req/ack handshake with variable latency (>=1 cycle).
Fills the IF/ID pipeline register, with stall, flush/redirect, a one-entry skid buffer and discard of in-flight fetches on redirect.

---
 rtl/fetch_stage_pkg.sv | 28 ++
 rtl/fetch_stage_if_id_reg.sv | 50 +++++
 rtl/fetch_stage.sv | 157 +++++++++++++++
 tb/tb_fetch_stage.sv | 379 +++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fetch_stage_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : fetch_stage_pkg
//  Description : Shared types and constants for the fetch stage and the
//                pipeline registers that follow it.
//  Revision    : 1.0 - initial release
// ============================================================================
package fetch_stage_pkg;

   localparam int XLEN = 32;

   // Bubble instruction: addi x0, x0, 0
   localparam logic [XLEN-1:0] c_nop_instr = 32'h0000_0013;
   localparam logic [XLEN-1:0] c_reset_pc  = 32'h0000_0000;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_FETCH = 2'd1,
      ST_HOLD  = 2'd2
   } fetch_state_t;

   // Sequential successor of a PC; wraps modulo 2^XLEN
   function automatic logic [XLEN-1:0] pc_plus4(input logic [XLEN-1:0] pc);
      return pc + 32'd4;
   endfunction

endpackage
`default_nettype wire

// File: rtl/fetch_stage_if_id_reg.sv
`default_nettype none
// ============================================================================
//  Module      : if_id_reg
//  Description : Pipeline register holding {pc, instr, valid} with hold,
//                load and bubble insertion. Bubble keeps pc, clears valid and
//                replaces the instruction with a NOP.
//  Revision    : 1.0 - initial release
// ============================================================================
module if_id_reg
   import fetch_stage_pkg::*;
#(
   parameter logic [XLEN-1:0] NOP_INSTR = c_nop_instr
) (
   input  logic            clk,
   input  logic            reset,
   input  logic            load,
   input  logic            bubble,
   input  logic [XLEN-1:0] pc_in,
   input  logic [XLEN-1:0] instr_in,
   output logic [XLEN-1:0] pc,
   output logic [XLEN-1:0] instr,
   output logic            valid
);

   logic [XLEN-1:0] r_pc;
   logic [XLEN-1:0] r_instr;
   logic            r_valid;

   // Register update: reset > bubble > load > hold
   always_ff @(posedge clk) begin
      if (reset) begin
         r_pc    <= '0;
         r_instr <= NOP_INSTR;
         r_valid <= 1'b0;
      end else if (bubble) begin
         r_instr <= NOP_INSTR;
         r_valid <= 1'b0;
      end else if (load) begin
         r_pc    <= pc_in;
         r_instr <= instr_in;
         r_valid <= 1'b1;
      end
   end

   assign pc    = r_pc;
   assign instr = r_instr;
   assign valid = r_valid;

endmodule
`default_nettype wire

// File: rtl/fetch_stage.sv
`default_nettype none
// ============================================================================
//  Module      : fetch_stage
//  Description : Instruction fetch. Owns the PC, issues req/ack fetches with
//                variable latency, fills IF/ID through a one-entry skid
//                buffer, and discards fetches that are in flight when a
//                flush redirects the stream.
//  Revision    : 1.0 - initial release
// ============================================================================
module fetch_stage
   import fetch_stage_pkg::*;
#(
   parameter logic [XLEN-1:0] RESET_PC  = c_reset_pc,
   parameter logic [XLEN-1:0] NOP_INSTR = c_nop_instr
) (
   input  logic            clk,
   input  logic            reset,
   input  logic [XLEN-1:0] pc_next,
   input  logic            stall,
   input  logic            flush,
   output logic            imem_req,
   output logic [XLEN-1:0] imem_addr,
   input  logic            imem_ack,
   input  logic [XLEN-1:0] imem_rdata,
   output logic [XLEN-1:0] pc_current,
   output logic [XLEN-1:0] add_pc_out,
   output logic [XLEN-1:0] if_id_pc,
   output logic [XLEN-1:0] if_id_instr,
   output logic            if_id_valid,
   output logic [XLEN-1:0] fetch_count
);

   fetch_state_t    r_state,        w_state_next;
   logic [XLEN-1:0] r_pc,           w_pc_next;
   logic            r_kill_pending, w_kill_next;
   logic [XLEN-1:0] r_redirect_pc,  w_redirect_next;
   logic            r_skid_valid,   w_skid_valid_next;
   logic [XLEN-1:0] r_skid_pc,      w_skid_pc_next;
   logic [XLEN-1:0] r_skid_instr,   w_skid_instr_next;
   logic [XLEN-1:0] r_fetch_count;

   logic            w_if_load;
   logic [XLEN-1:0] w_if_pc;
   logic [XLEN-1:0] w_if_instr;

   // State and datapath registers
   always_ff @(posedge clk) begin
      if (reset) begin
         r_state        <= ST_IDLE;
         r_pc           <= RESET_PC;
         r_kill_pending <= 1'b0;
         r_redirect_pc  <= '0;
         r_skid_valid   <= 1'b0;
         r_skid_pc      <= '0;
         r_skid_instr   <= '0;
         r_fetch_count  <= '0;
      end else begin
         r_state        <= w_state_next;
         r_pc           <= w_pc_next;
         r_kill_pending <= w_kill_next;
         r_redirect_pc  <= w_redirect_next;
         r_skid_valid   <= w_skid_valid_next;
         r_skid_pc      <= w_skid_pc_next;
         r_skid_instr   <= w_skid_instr_next;
         if (w_if_load && !flush)
            r_fetch_count <= r_fetch_count + 32'd1;
      end
   end

   // Next-state, PC, kill and skid decisions. A flush never moves the address
   // of an outstanding request; it only arms the kill so the late data is
   // dropped and the redirect target is fetched afterwards.
   always_comb begin
      w_state_next      = r_state;
      w_pc_next         = r_pc;
      w_kill_next       = r_kill_pending;
      w_redirect_next   = r_redirect_pc;
      w_skid_valid_next = r_skid_valid;
      w_skid_pc_next    = r_skid_pc;
      w_skid_instr_next = r_skid_instr;
      w_if_load         = 1'b0;
      w_if_pc           = r_pc;
      w_if_instr        = imem_rdata;

      case (r_state)
         ST_IDLE: begin
            w_state_next = ST_FETCH;
            if (flush)
               w_pc_next = pc_next;
         end

         ST_FETCH: begin
            if (imem_ack) begin
               if (flush) begin
                  w_pc_next   = pc_next;
                  w_kill_next = 1'b0;
               end else if (r_kill_pending) begin
                  w_pc_next   = r_redirect_pc;
                  w_kill_next = 1'b0;
               end else if (!stall) begin
                  w_if_load = 1'b1;
                  w_pc_next = pc_next;
               end else begin
                  w_skid_valid_next = 1'b1;
                  w_skid_pc_next    = r_pc;
                  w_skid_instr_next = imem_rdata;
                  w_pc_next         = pc_next;
                  w_state_next      = ST_HOLD;
               end
            end else if (flush) begin
               w_redirect_next = pc_next;
               w_kill_next     = 1'b1;
            end
         end

         ST_HOLD: begin
            if (flush) begin
               w_skid_valid_next = 1'b0;
               w_pc_next         = pc_next;
               w_state_next      = ST_FETCH;
            end else if (!stall) begin
               w_if_load         = r_skid_valid;
               w_if_pc           = r_skid_pc;
               w_if_instr        = r_skid_instr;
               w_skid_valid_next = 1'b0;
               w_state_next      = ST_FETCH;
            end
         end

         default: begin
            w_state_next = ST_IDLE;
         end
      endcase
   end

   if_id_reg #(
      .NOP_INSTR (NOP_INSTR)
   ) u_if_id_reg (
      .clk      (clk),
      .reset    (reset),
      .load     (w_if_load),
      .bubble   (flush),
      .pc_in    (w_if_pc),
      .instr_in (w_if_instr),
      .pc       (if_id_pc),
      .instr    (if_id_instr),
      .valid    (if_id_valid)
   );

   assign imem_req    = (r_state == ST_FETCH);
   assign imem_addr   = r_pc;
   assign pc_current  = r_pc;
   assign add_pc_out  = pc_plus4(r_pc);
   assign fetch_count = r_fetch_count;

endmodule
`default_nettype wire

// File: tb/tb_fetch_stage.sv
`default_nettype none
// ============================================================================
//  Module      : tb_fetch_stage
//  Description : Self-checking bench for fetch_stage: directed scenarios
//                followed by randomized traffic against a reference model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_fetch_stage;

   localparam logic [31:0] K   = 32'hA5A5_0000;
   localparam logic [31:0] NOP = 32'h0000_0013;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        stall = 1'b0;
   logic        flush = 1'b0;
   logic        use_add = 1'b1;
   logic        mem_auto = 1'b1;
   logic [31:0] pc_next_drv = '0;
   logic        ack_drv = 1'b0;
   logic [31:0] rdata_drv = '0;

   logic [31:0] pc_next;
   logic        imem_req;
   logic [31:0] imem_addr;
   logic        imem_ack;
   logic [31:0] imem_rdata;
   logic [31:0] pc_current;
   logic [31:0] add_pc_out;
   logic [31:0] if_id_pc;
   logic [31:0] if_id_instr;
   logic        if_id_valid;
   logic [31:0] fetch_count;

   int n_cmp  = 0;
   int n_fail = 0;

   // pc_mux stand-in and a 1-cycle memory for the simple directed scenarios
   assign pc_next    = use_add  ? add_pc_out : pc_next_drv;
   assign imem_ack   = mem_auto ? imem_req : ack_drv;
   assign imem_rdata = mem_auto ? (imem_addr ^ K) : rdata_drv;

   fetch_stage dut (
      .clk         (clk),
      .reset       (reset),
      .pc_next     (pc_next),
      .stall       (stall),
      .flush       (flush),
      .imem_req    (imem_req),
      .imem_addr   (imem_addr),
      .imem_ack    (imem_ack),
      .imem_rdata  (imem_rdata),
      .pc_current  (pc_current),
      .add_pc_out  (add_pc_out),
      .if_id_pc    (if_id_pc),
      .if_id_instr (if_id_instr),
      .if_id_valid (if_id_valid),
      .fetch_count (fetch_count)
   );

   always #5 clk = ~clk;

   typedef logic [129:0] snap_t;

   // {req, addr, valid, if_id_pc, if_id_instr, fetch_count}
   function automatic snap_t snap();
      return {imem_req, imem_addr, if_id_valid, if_id_pc, if_id_instr, fetch_count};
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      snap_t exp;
      reset = 1'b1; use_add = 1'b1; mem_auto = 1'b1; stall = 1'b0; flush = 1'b0;
      tick(); tick();
      exp = {1'b0, 32'h0, 1'b0, 32'h0, NOP, 32'h0};
      n_cmp++;
      if (snap() !== exp) begin
         n_fail++;
         $display("FAIL reset_state: got %h want %h", snap(), exp);
      end
      n_cmp++;
      if (add_pc_out !== 32'h4) begin
         n_fail++;
         $display("FAIL reset_add_pc: got %h want %h", add_pc_out, 32'h4);
      end
   endtask

   task automatic test_back_to_back();
      snap_t exp;
      reset = 1'b0;
      tick();
      exp = {1'b1, 32'h0, 1'b0, 32'h0, NOP, 32'h0};
      n_cmp++;
      if (snap() !== exp) begin
         n_fail++;
         $display("FAIL b2b_first_req: got %h want %h", snap(), exp);
      end
      for (int i = 0; i < 4; i++) begin
         logic [31:0] p;
         p = 32'(i) * 32'd4;
         tick();
         exp = {1'b1, p + 32'd4, 1'b1, p, p ^ K, 32'(i + 1)};
         n_cmp++;
         if (snap() !== exp) begin
            n_fail++;
            $display("FAIL b2b_%0d: got %h want %h", i, snap(), exp);
         end
      end
   endtask

   task automatic test_stall_hold();
      snap_t exp;
      stall = 1'b1;
      for (int i = 0; i < 3; i++) begin
         tick();
         exp = {1'b0, 32'h14, 1'b1, 32'hC, 32'hC ^ K, 32'd4};
         n_cmp++;
         if (snap() !== exp) begin
            n_fail++;
            $display("FAIL stall_hold_%0d: got %h want %h", i, snap(), exp);
         end
      end
      stall = 1'b0;
      tick();
      exp = {1'b1, 32'h14, 1'b1, 32'h10, 32'h10 ^ K, 32'd5};
      n_cmp++;
      if (snap() !== exp) begin
         n_fail++;
         $display("FAIL stall_release: got %h want %h", snap(), exp);
      end
      tick();
      exp = {1'b1, 32'h18, 1'b1, 32'h14, 32'h14 ^ K, 32'd6};
      n_cmp++;
      if (snap() !== exp) begin
         n_fail++;
         $display("FAIL stall_resume: got %h want %h", snap(), exp);
      end
   endtask

   task automatic test_flush_with_ack();
      snap_t exp;
      mem_auto = 1'b0; use_add = 1'b0; ack_drv = 1'b0;
      reset = 1'b1;
      tick();
      reset = 1'b0;
      tick();
      flush = 1'b1; ack_drv = 1'b1; rdata_drv = 32'hDEAD_BEEF; pc_next_drv = 32'h80;
      tick();
      exp = {1'b1, 32'h80, 1'b0, 32'h0, NOP, 32'h0};
      n_cmp++;
      if (snap() !== exp) begin
         n_fail++;
         $display("FAIL flush_ack_drop: got %h want %h", snap(), exp);
      end
      flush = 1'b0; ack_drv = 1'b1; rdata_drv = 32'h80 ^ K; pc_next_drv = 32'h40;
      tick();
      exp = {1'b1, 32'h40, 1'b1, 32'h80, 32'h80 ^ K, 32'd1};
      n_cmp++;
      if (snap() !== exp) begin
         n_fail++;
         $display("FAIL flush_ack_no_kill: got %h want %h", snap(), exp);
      end
   endtask

   task automatic test_flush_inflight();
      snap_t exp;
      ack_drv = 1'b0; flush = 1'b1; pc_next_drv = 32'h200;
      tick();
      exp = {1'b1, 32'h40, 1'b0, 32'h80, NOP, 32'd1};
      n_cmp++;
      if (snap() !== exp) begin
         n_fail++;
         $display("FAIL inflight_flush: got %h want %h", snap(), exp);
      end
      flush = 1'b0; pc_next_drv = 32'h300;
      tick();
      n_cmp++;
      if (snap() !== exp) begin
         n_fail++;
         $display("FAIL inflight_wait: got %h want %h", snap(), exp);
      end
      ack_drv = 1'b1; rdata_drv = 32'hDEAD_0040;
      tick();
      exp = {1'b1, 32'h200, 1'b0, 32'h80, NOP, 32'd1};
      n_cmp++;
      if (snap() !== exp) begin
         n_fail++;
         $display("FAIL inflight_discard: got %h want %h", snap(), exp);
      end
      rdata_drv = 32'h200 ^ K; pc_next_drv = 32'h204;
      tick();
      exp = {1'b1, 32'h204, 1'b1, 32'h200, 32'h200 ^ K, 32'd2};
      n_cmp++;
      if (snap() !== exp) begin
         n_fail++;
         $display("FAIL inflight_redirect: got %h want %h", snap(), exp);
      end
   endtask

   task automatic test_flush_stall_hold();
      snap_t exp;
      stall = 1'b1; ack_drv = 1'b1; rdata_drv = 32'h204 ^ K; pc_next_drv = 32'h208;
      tick();
      exp = {1'b0, 32'h208, 1'b1, 32'h200, 32'h200 ^ K, 32'd2};
      n_cmp++;
      if (snap() !== exp) begin
         n_fail++;
         $display("FAIL hold_enter: got %h want %h", snap(), exp);
      end
      flush = 1'b1; ack_drv = 1'b0; pc_next_drv = 32'h500;
      tick();
      exp = {1'b1, 32'h500, 1'b0, 32'h200, NOP, 32'd2};
      n_cmp++;
      if (snap() !== exp) begin
         n_fail++;
         $display("FAIL hold_flush: got %h want %h", snap(), exp);
      end
      flush = 1'b0; stall = 1'b0;
      tick();
      n_cmp++;
      if (snap() !== exp) begin
         n_fail++;
         $display("FAIL hold_skid_cleared: got %h want %h", snap(), exp);
      end
      ack_drv = 1'b1; rdata_drv = 32'h500 ^ K; pc_next_drv = 32'h504;
      tick();
      exp = {1'b1, 32'h504, 1'b1, 32'h500, 32'h500 ^ K, 32'd3};
      n_cmp++;
      if (snap() !== exp) begin
         n_fail++;
         $display("FAIL hold_after_flush: got %h want %h", snap(), exp);
      end
   endtask

   task automatic test_reset_midfetch();
      snap_t exp;
      flush = 1'b1; ack_drv = 1'b1; pc_next_drv = 32'h30;
      tick();
      flush = 1'b0; ack_drv = 1'b0;
      tick();
      n_cmp++;
      if (imem_addr !== 32'h30 || imem_req !== 1'b1) begin
         n_fail++;
         $display("FAIL midfetch_setup: got req=%b addr=%h want req=1 addr=00000030", imem_req, imem_addr);
      end
      reset = 1'b1; ack_drv = 1'b1; rdata_drv = 32'h30 ^ K;
      tick();
      exp = {1'b0, 32'h0, 1'b0, 32'h0, NOP, 32'h0};
      n_cmp++;
      if (snap() !== exp) begin
         n_fail++;
         $display("FAIL midfetch_reset: got %h want %h", snap(), exp);
      end
      reset = 1'b0; pc_next_drv = 32'h34;
      tick();
      exp = {1'b1, 32'h0, 1'b0, 32'h0, NOP, 32'h0};
      n_cmp++;
      if (snap() !== exp) begin
         n_fail++;
         $display("FAIL midfetch_late_ack: got %h want %h", snap(), exp);
      end
      rdata_drv = 32'h0 ^ K; pc_next_drv = 32'h4;
      tick();
      exp = {1'b1, 32'h4, 1'b1, 32'h0, K, 32'd1};
      n_cmp++;
      if (snap() !== exp) begin
         n_fail++;
         $display("FAIL midfetch_first_fetch: got %h want %h", snap(), exp);
      end
      ack_drv = 1'b0;
   endtask

   // Randomized traffic with a variable-latency memory; the model tracks
   // what the fetch stage is doing (waiting to start, requesting, or
   // holding one captured instruction) and what IF/ID should contain.
   task automatic test_random();
      bit          m_start, m_req, m_hold, m_kill, m_ifv;
      logic [31:0] m_pc, m_redir, m_spc, m_sinstr, m_ifpc, m_ifinstr, m_cnt;
      int          wait_left;
      bit          r, s, f, a;
      logic [31:0] pn, rd;
      snap_t       exp;

      mem_auto = 1'b0; use_add = 1'b0; ack_drv = 1'b0; stall = 1'b0; flush = 1'b0;
      reset = 1'b1;
      tick();
      m_start = 1; m_req = 0; m_hold = 0; m_kill = 0; m_ifv = 0;
      m_pc = 0; m_redir = 0; m_spc = 0; m_sinstr = 0;
      m_ifpc = 0; m_ifinstr = NOP; m_cnt = 0; wait_left = -1;

      for (int cyc = 0; cyc < 3000; cyc++) begin
         r  = ($urandom_range(0, 199) == 0);
         s  = ($urandom_range(0, 3) == 0);
         f  = ($urandom_range(0, 11) == 0);
         pn = ($urandom_range(0, 2) != 0) ? m_pc + 32'd4 : $urandom;
         a  = 0;
         if (m_req) begin
            if (wait_left < 0) wait_left = $urandom_range(0, 2);
            a = (wait_left == 0);
         end
         rd = a ? (m_pc ^ K) : $urandom;

         reset = r; stall = s; flush = f; pc_next_drv = pn; ack_drv = a; rdata_drv = rd;
         tick();

         if (r || a) wait_left = -1;
         else if (wait_left > 0) wait_left--;

         if (r) begin
            m_start = 1; m_req = 0; m_hold = 0; m_kill = 0; m_ifv = 0;
            m_pc = 0; m_ifpc = 0; m_ifinstr = NOP; m_cnt = 0;
         end else begin
            if (f) begin
               m_ifv = 0; m_ifinstr = NOP;
            end
            if (m_start) begin
               m_start = 0; m_req = 1;
               if (f) m_pc = pn;
            end else if (m_req) begin
               if (a) begin
                  if (f) begin
                     m_pc = pn; m_kill = 0;
                  end else if (m_kill) begin
                     m_pc = m_redir; m_kill = 0;
                  end else if (!s) begin
                     m_ifv = 1; m_ifpc = m_pc; m_ifinstr = rd; m_cnt++;
                     m_pc = pn;
                  end else begin
                     m_spc = m_pc; m_sinstr = rd; m_pc = pn;
                     m_req = 0; m_hold = 1;
                  end
               end else if (f) begin
                  m_redir = pn; m_kill = 1;
               end
            end else if (m_hold) begin
               if (f) begin
                  m_pc = pn; m_hold = 0; m_req = 1;
               end else if (!s) begin
                  m_ifv = 1; m_ifpc = m_spc; m_ifinstr = m_sinstr; m_cnt++;
                  m_hold = 0; m_req = 1;
               end
            end
         end

         exp = {m_req, m_pc, m_ifv, m_ifpc, m_ifinstr, m_cnt};
         n_cmp++;
         if (snap() !== exp) begin
            n_fail++;
            $display("FAIL rand_cyc%0d: got %h want %h", cyc, snap(), exp);
         end
         n_cmp++;
         if (pc_current !== m_pc || add_pc_out !== m_pc + 32'd4) begin
            n_fail++;
            $display("FAIL rand_pc_cyc%0d: got pc=%h add=%h want pc=%h add=%h",
                     cyc, pc_current, add_pc_out, m_pc, m_pc + 32'd4);
         end
      end
      reset = 1'b0; stall = 1'b0; flush = 1'b0; ack_drv = 1'b0;
   endtask

   initial begin
      test_reset();
      test_back_to_back();
      test_stall_hold();
      test_flush_with_ack();
      test_flush_inflight();
      test_flush_stall_hold();
      test_reset_midfetch();
      test_random();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
`default_nettype wire
